fifo_pack_reader: RTL

- Downstream consumer of sync_fifo: pops DATA_WIDTH words from the FIFO read port and packs PACK_RATIO of them into one wide beat.
- Presents each beat on a valid/ready output stream.
- Supports a flush request that emits a trailing partial beat with a lane-keep mask.

---
 rtl/fifo_pack_reader_pkg.sv | 17 +
 rtl/fifo_pack_reader_if.sv | 26 ++
 rtl/fifo_pack_defs.vh | 14 +
 rtl/fifo_pack_out_reg.sv | 36 +++
 rtl/sync_fifo.sv | 48 ++++
 rtl/fifo_pack_reader.sv | 148 ++++++++++++++
 6 files changed

// File: rtl/fifo_pack_reader_pkg.sv
// Types and defaults shared by the pack reader files.
// No logic; state encodings come from fifo_pack_defs.vh.
// Backpressure: n/a.
package fifo_pack_reader_pkg;

`include "fifo_pack_defs.vh"

    typedef enum logic [1:0] {
        ST_FILL  = `FIFO_PACK_ST_FILL,
        ST_HOLD  = `FIFO_PACK_ST_HOLD,
        ST_FLUSH = `FIFO_PACK_ST_FLUSH
    } state_e;

    localparam int DEF_DATA_WIDTH = `FIFO_PACK_DATA_WIDTH;
    localparam int DEF_PACK_RATIO = `FIFO_PACK_PACK_RATIO;

endpackage

// File: rtl/fifo_pack_reader_if.sv
// Bundles the FIFO read port, the packed output stream and the flush pulse.
// master = pack reader side, slave = FIFO/consumer side.
// Backpressure: out_ready stalls the output stream; fifo_rd_empty stalls reads.
interface fifo_pack_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PACK_RATIO = 2
);
    logic                             fifo_rd_empty;
    logic                             fifo_rd_en;
    logic [DATA_WIDTH-1:0]            fifo_rd_data;
    logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
    logic [PACK_RATIO-1:0]            out_keep;
    logic                             out_valid;
    logic                             out_ready;
    logic                             flush;

    modport master (
        input  fifo_rd_empty, fifo_rd_data, out_ready, flush,
        output fifo_rd_en, out_data, out_keep, out_valid
    );

    modport slave (
        output fifo_rd_empty, fifo_rd_data, out_ready, flush,
        input  fifo_rd_en, out_data, out_keep, out_valid
    );
endinterface

// File: rtl/fifo_pack_defs.vh
// Shared encodings and defaults for the FIFO pack reader.
// FSM state codes are fixed so traces and other tools can decode them.
// Default word width and pack ratio match the upstream sync_fifo.
`ifndef FIFO_PACK_DEFS_VH
`define FIFO_PACK_DEFS_VH

`define FIFO_PACK_ST_FILL      2'd0
`define FIFO_PACK_ST_HOLD      2'd1
`define FIFO_PACK_ST_FLUSH     2'd2

`define FIFO_PACK_DATA_WIDTH   16
`define FIFO_PACK_PACK_RATIO   2

`endif

// File: rtl/fifo_pack_out_reg.sv
// Valid/ready output register slice for packed beats.
// Latency: one cycle from load to out_valid.
// Backpressure: holds data/keep stable while out_valid && !out_ready; free when empty or draining.
// Ports: load/load_data/load_keep in, out_* stream, free tells the producer a load is accepted.
module fifo_pack_out_reg #(
    parameter int WIDTH = 32,
    parameter int LANES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LANES-1:0] load_keep,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LANES-1:0] out_keep,
    output logic             out_valid,
    output logic             free
);
    // A consumed beat frees the slot on the same edge, allowing back-to-back beats.
    assign free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered read data.
// Latency: rd_data valid one cycle after rd_en; write visible the cycle after wr_en.
// Backpressure: writes dropped when full, reads ignored when empty.
// Ports: clk/reset, wr_en/wr_data/full write side, rd_en/rd_data/empty read side.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_pack_reader.sv
// Pops FIFO words and packs PACK_RATIO of them (lane 0 = first word) into one beat; flush emits a partial beat.
// Latency: beat valid two cycles after the last word's pop; PACK_RATIO words per PACK_RATIO+1 cycles sustained.
// Backpressure: a busy output register parks the full beat (HOLD) and stops further pops.
// Ports: clk, reset (sync, active-high), bus (fifo_pack_reader_if.master).
// Optional FIFO_PACK_STATS_EN adds stat_beats / stat_partial accepted-beat counters.
module fifo_pack_reader
    import fifo_pack_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK_RATIO = DEF_PACK_RATIO
) (
    input  logic                   clk,
    input  logic                   reset,
    fifo_pack_reader_if.master     bus
`ifdef FIFO_PACK_STATS_EN
    ,
    output logic [15:0]            stat_beats,
    output logic [7:0]             stat_partial
`endif
);
    localparam int LW = $clog2(PACK_RATIO + 1);

    state_e                                  state;
    logic [LW-1:0]                           lanes;
    logic [LW-1:0]                           lanes_land;
    logic                                    inflight;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]   acc;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]   acc_land;
    logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]   load_data;
    logic [PACK_RATIO-1:0]                   load_keep;
    logic [PACK_RATIO-1:0]                   part_keep;
    logic                                    out_free;
    logic                                    load_full;
    logic                                    load_partial;
    logic                                    flush_pending;
    logic                                    flush_done;

    assign flush_pending = (state == ST_FLUSH);

    // Counting the in-flight word as a lane keeps pops bounded by free lanes.
    assign bus.fifo_rd_en = !bus.fifo_rd_empty && !flush_pending && !reset &&
                            ((int'(lanes) + int'(inflight)) < PACK_RATIO);

    // Accumulator view with this cycle's landing word merged in.
    always_comb begin
        acc_land   = acc;
        lanes_land = lanes;
        if (inflight) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (lanes == LW'(i)) begin
                    acc_land[i] = bus.fifo_rd_data;
                end
            end
            lanes_land = lanes + LW'(1);
        end
    end

    always_comb begin
        part_keep = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            part_keep[i] = (LW'(i) < lanes);
        end
    end

    // Full beat covers both a completing landing word and a parked HOLD beat.
    assign load_full    = (int'(lanes_land) == PACK_RATIO) && out_free;
    assign load_partial = flush_pending && !inflight && (lanes != '0) &&
                          (int'(lanes) < PACK_RATIO) && out_free;
    assign flush_done   = flush_pending && !inflight &&
                          ((lanes == '0) || load_partial);

    assign load_keep = load_full ? {PACK_RATIO{1'b1}} : part_keep;

    // Stale lanes from earlier beats are zeroed in partial beats.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < PACK_RATIO; i++) begin
            load_data[i] = load_keep[i] ? acc_land[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        acc <= acc_land;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_FILL;
            lanes    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_rd_en;
            lanes    <= (load_full || load_partial) ? '0 : lanes_land;
            unique case (state)
                ST_FILL: begin
                    if (bus.flush) begin
                        state <= ST_FLUSH;
                    end else if ((int'(lanes_land) == PACK_RATIO) && !out_free) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.flush) begin
                        state <= ST_FLUSH;
                    end else if (out_free) begin
                        state <= ST_FILL;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done) begin
                        state <= ST_FILL;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

    fifo_pack_out_reg #(
        .WIDTH (DATA_WIDTH * PACK_RATIO),
        .LANES (PACK_RATIO)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load_full || load_partial),
        .load_data (load_data),
        .load_keep (load_keep),
        .out_ready (bus.out_ready),
        .out_data  (bus.out_data),
        .out_keep  (bus.out_keep),
        .out_valid (bus.out_valid),
        .free      (out_free)
    );

`ifdef FIFO_PACK_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_beats   <= '0;
            stat_partial <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            stat_beats <= stat_beats + 16'd1;
            if (bus.out_keep != {PACK_RATIO{1'b1}}) begin
                stat_partial <= stat_partial + 8'd1;
            end
        end
    end
`endif
endmodule
